writeback_arbiter_20: RTL

Writeback stage directly upstream of the 8-entry, 20-bit register file; sole driver of its WE3/A3/WD3 write port. Merges single-cycle ALU results with variable-latency memory load returns. Load returns are held in a small FIFO; ALU results always have priority. A per-register pending-load scoreboard gives decode a busy view for hazard stalls.

---
 rtl/writeback_arbiter_20.sv | 137 +++++++++++++
 1 files changed

// File: rtl/writeback_arbiter_20.sv
`default_nettype none
// ==========================================================================
// writeback_arbiter_20: ALU/load-return writeback merge, load FIFO, pending-load scoreboard
// Revision: 1.0
// ==========================================================================
module writeback_arbiter_20 #(
    parameter int DATA_W     = 20,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_rd,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          mem_valid,
    input  logic [ADDR_W-1:0]             mem_rd,
    input  logic [DATA_W-1:0]             mem_data,
    output logic                          mem_ready,
    input  logic                          issue_valid,
    input  logic [ADDR_W-1:0]             issue_rd,
    output logic                          issue_stall,
    output logic [(2**ADDR_W)-1:0]        busy,
    output logic                          WE3,
    output logic [ADDR_W-1:0]             A3,
    output logic [DATA_W-1:0]             WD3,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ovf_err,
    output logic                          waw_err
);

    localparam int NREG  = 2**ADDR_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [1:0]        cnt       [NREG];

    logic              enq;
    logic              deq;
    logic              drop;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;
    logic [NREG-1:0]   inc_vec;
    logic [NREG-1:0]   dec_vec;

    // Readiness comes from the registered count only, so a same-cycle dequeue never frees a slot early.
    assign mem_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign enq       = mem_valid & mem_ready;
    assign drop      = mem_valid & ~mem_ready;
    assign deq       = ~alu_valid & (fifo_count != '0);
    assign head_rd   = fifo_rd[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    assign issue_stall = issue_valid && (cnt[issue_rd] == 2'd3);

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[wr_ptr]   <= mem_rd;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            unique case ({enq, deq})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WE3 <= 1'b0;
            A3  <= '0;
            WD3 <= '0;
        end else if (alu_valid) begin
            WE3 <= (alu_rd != '0);
            A3  <= alu_rd;
            WD3 <= alu_data;
        end else if (deq) begin
            WE3 <= (head_rd != '0);
            A3  <= head_rd;
            WD3 <= head_data;
        end else begin
            WE3 <= 1'b0;
        end
    end

    // Register 0 is skipped entirely; its counter stays at its reset value.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        busy    = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_vec[r] = issue_valid && !issue_stall && (issue_rd == ADDR_W'(r));
            dec_vec[r] = deq && (head_rd == ADDR_W'(r)) && (cnt[r] != 2'd0);
            busy[r]    = (cnt[r] != 2'd0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= 2'd0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    cnt[r] <= cnt[r] + 2'd1;
                else if (dec_vec[r] && !inc_vec[r])
                    cnt[r] <= cnt[r] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err <= 1'b0;
            waw_err <= 1'b0;
        end else begin
            if (drop) ovf_err <= 1'b1;
            if (alu_valid && (alu_rd != '0) && busy[alu_rd]) waw_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire
